ping_pong_decoder: RTL

//  Receive-side checker for a bouncing one-hot LED array (ping-pong pattern generator output).

---
 rtl/ping_pong_decoder.sv | 96 +++++++++
 1 files changed

// File: rtl/ping_pong_decoder.sv
// ping_pong_decoder: tracks a bouncing one-hot array, decodes position/direction, counts bounces, flags errors
module ping_pong_decoder #(
   parameter int width = 8,
   parameter int IDX_W = $clog2(width),
   parameter int CNT_W = 16
) (
   input  logic             inclk,
   input  logic             reset,
   input  logic [width-1:0] array_in,
   input  logic             sample_en,
   input  logic             resync,
   output logic [IDX_W-1:0] position,
   output logic             direction,
   output logic             valid,
   output logic [CNT_W-1:0] bounce_count,
   output logic             error,
   output logic [1:0]       err_code
);
   typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, ERROR} state_t;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(width - 1);
   state_t           state_q;
   logic [IDX_W-1:0] position_q;
   logic             direction_q;
   logic             valid_q;
   logic [CNT_W-1:0] bounce_q;
   logic             error_q;
   logic [1:0]       err_code_q;
   logic [IDX_W-1:0] idx;
   logic [IDX_W:0]   cur, pos_ext;
   logic             one_hot, same, step_up, step_dn, fwd, back, at_edge;
   always_comb begin
      idx = '0;
      for (int i = 0; i < width; i++) if (array_in[i]) idx = IDX_W'(i);
   end
   // one extra index bit keeps 0-1 from aliasing onto width-1
   assign one_hot = $onehot(array_in);
   assign cur     = {1'b0, idx};
   assign pos_ext = {1'b0, position_q};
   assign same    = cur == pos_ext;
   assign step_up = cur == pos_ext + (IDX_W+1)'(1);
   assign step_dn = cur == pos_ext - (IDX_W+1)'(1);
   assign fwd     = direction_q ? step_dn : step_up;
   assign back    = direction_q ? step_up : step_dn;
   assign at_edge = direction_q ? position_q == '0 : position_q == LAST;
   always_ff @(posedge inclk) begin
      if (reset) begin
         state_q     <= IDLE;
         position_q  <= '0;
         direction_q <= 1'b0;
         valid_q     <= 1'b0;
         bounce_q    <= '0;
         error_q     <= 1'b0;
         err_code_q  <= 2'b00;
      end else if (resync) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         bounce_q   <= '0;
         error_q    <= 1'b0;
         err_code_q <= 2'b00;
      end else if (sample_en && state_q != ERROR) begin
         if (!one_hot) begin
            state_q    <= ERROR;
            valid_q    <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= 2'b01;
         end else if (state_q == IDLE) begin
            position_q <= idx;
            state_q    <= ACQUIRE;
         end else if (!same) begin
            if (state_q == ACQUIRE && (step_up || step_dn)) begin
               position_q  <= idx;
               direction_q <= step_dn;
               state_q     <= TRACK;
               valid_q     <= 1'b1;
            end else if (state_q == TRACK && fwd) begin
               position_q <= idx;
            end else if (state_q == TRACK && back && at_edge) begin
               position_q  <= idx;
               direction_q <= ~direction_q;
               bounce_q    <= bounce_q == '1 ? bounce_q : bounce_q + 1'b1;
            end else begin
               state_q    <= ERROR;
               valid_q    <= 1'b0;
               error_q    <= 1'b1;
               err_code_q <= 2'b10;
            end
         end
      end
   end
   assign position     = position_q;
   assign direction    = direction_q;
   assign valid        = valid_q;
   assign bounce_count = bounce_q;
   assign error        = error_q;
   assign err_code     = err_code_q;
endmodule
